// File: rtl/mdu_seq_if.sv
// mdu_seq_if -- handshake/data bundle between a requester and mdu_seq.
//   master : drives start/op/a/b/hi_we/lo_we/wdata, observes busy/done/hi/lo/div_zero
//   slave  : the multiply/divide unit itself
interface mdu_seq_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             hi_we;
   logic             lo_we;
   logic [WIDTH-1:0] wdata;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             div_zero;

   modport master (
      output start, op, a, b, hi_we, lo_we, wdata,
      input  busy, done, hi, lo, div_zero
   );

   modport slave (
      input  start, op, a, b, hi_we, lo_we, wdata,
      output busy, done, hi, lo, div_zero
   );
endinterface

// File: rtl/mdu_seq.sv
// mdu_seq -- sequential radix-2 multiply/divide unit with hi/lo result registers.
//   clk, rst_n : single clock, asynchronous active-low reset
//   bus.start/op/a/b : request; op 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   bus.hi_we/lo_we/wdata : direct writes to hi/lo while idle
//   bus.busy/done/hi/lo/div_zero : status and registered results
// One shift-add (multiply) or restoring-subtract (divide) step per cycle on
// magnitudes; signs are fixed up in a final FIX cycle. Latency WIDTH+1.
// Macro MDU_SEQ_DIV_EN enables the divide datapath; without it DIV/DIVU
// requests are refused and div_zero is tied low.
module mdu_seq #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic      clk,
   input  logic      rst_n,
   mdu_seq_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t             state, state_nx;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH-1:0]   acc;      // product upper half / partial remainder
   logic [WIDTH-1:0]   mq;       // multiplier / dividend, shifts into product low / quotient
   logic [WIDTH-1:0]   opd;      // multiplicand / divisor magnitude
   logic               neg_lo;   // negate product (mult) or quotient (div)
   logic [WIDTH-1:0]   hi_r, lo_r;
   logic               done_r;
   logic               busy;
   logic               accept;
   logic               op_ok;

   // operand magnitudes; signed ops are 00 and 10
   logic               sgn, a_neg, b_neg;
   logic [WIDTH-1:0]   a_abs, b_abs;

   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] prod, prod_fix;

   assign sgn   = ~bus.op[0];
   assign a_neg = sgn & bus.a[WIDTH-1];
   assign b_neg = sgn & bus.b[WIDTH-1];
   assign a_abs = a_neg ? -bus.a : bus.a;
   assign b_abs = b_neg ? -bus.b : bus.b;

   assign mul_sum  = {1'b0, acc} + (mq[0] ? {1'b0, opd} : '0);
   assign prod     = {acc, mq};
   assign prod_fix = neg_lo ? -prod : prod;

`ifdef MDU_SEQ_DIV_EN
   logic               is_div, neg_hi, dz, dz_r, b_zero;
   logic [WIDTH:0]     rem_sh;
   logic [WIDTH+1:0]   diff;     // extra bit is the borrow
   logic [WIDTH-1:0]   q_fix, r_fix;

   assign op_ok  = 1'b1;
   assign b_zero = (bus.b == '0);
   assign rem_sh = {acc, mq[WIDTH-1]};
   assign diff   = {1'b0, rem_sh} - {2'b0, opd};
   assign q_fix  = neg_lo ? -mq  : mq;
   assign r_fix  = neg_hi ? -acc : acc;
   assign bus.div_zero = dz_r;
`else
   assign op_ok  = ~bus.op[1];
   assign bus.div_zero = 1'b0;
`endif

   assign accept   = bus.start & (state == IDLE) & op_ok;
   assign bus.busy = busy;
   assign bus.done = done_r;
   assign bus.hi   = hi_r;
   assign bus.lo   = lo_r;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      busy     = (state != IDLE);
      case (state)
         IDLE:    if (accept) state_nx = RUN;
         RUN:     if (cnt == CNT_W'(1)) state_nx = FIX;
         FIX:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= '0;
         acc    <= '0;
         mq     <= '0;
         opd    <= '0;
         neg_lo <= 1'b0;
         hi_r   <= '0;
         lo_r   <= '0;
         done_r <= 1'b0;
`ifdef MDU_SEQ_DIV_EN
         is_div <= 1'b0;
         neg_hi <= 1'b0;
         dz     <= 1'b0;
         dz_r   <= 1'b0;
`endif
      end else begin
         done_r <= 1'b0;
         // direct writes only while idle; a FIX write later overrides them
         if (state == IDLE) begin
            if (bus.hi_we) hi_r <= bus.wdata;
            if (bus.lo_we) lo_r <= bus.wdata;
         end
         if (accept) begin
            cnt <= CNT_W'(WIDTH);
            acc <= '0;
`ifdef MDU_SEQ_DIV_EN
            is_div <= bus.op[1];
            dz_r   <= 1'b0;
            if (bus.op[1]) begin
               // divide by zero: feed the raw dividend through so the
               // restoring loop leaves hi = a and lo = all ones untouched
               mq     <= b_zero ? bus.a : a_abs;
               opd    <= b_abs;
               neg_lo <= ~b_zero & (a_neg ^ b_neg);
               neg_hi <= ~b_zero & a_neg;
               dz     <= b_zero;
            end else begin
               mq     <= b_abs;
               opd    <= a_abs;
               neg_lo <= a_neg ^ b_neg;
               neg_hi <= 1'b0;
               dz     <= 1'b0;
            end
`else
            mq     <= b_abs;
            opd    <= a_abs;
            neg_lo <= a_neg ^ b_neg;
`endif
         end
         if (state == RUN) begin
            cnt <= cnt - CNT_W'(1);
`ifdef MDU_SEQ_DIV_EN
            if (is_div) begin
               if (!diff[WIDTH+1]) begin
                  acc <= diff[WIDTH-1:0];
                  mq  <= {mq[WIDTH-2:0], 1'b1};
               end else begin
                  acc <= rem_sh[WIDTH-1:0];
                  mq  <= {mq[WIDTH-2:0], 1'b0};
               end
            end else begin
               acc <= mul_sum[WIDTH:1];
               mq  <= {mul_sum[0], mq[WIDTH-1:1]};
            end
`else
            acc <= mul_sum[WIDTH:1];
            mq  <= {mul_sum[0], mq[WIDTH-1:1]};
`endif
         end
         if (state == FIX) begin
            done_r <= 1'b1;
`ifdef MDU_SEQ_DIV_EN
            if (is_div) begin
               hi_r <= r_fix;
               lo_r <= q_fix;
               dz_r <= dz;
            end else begin
               {hi_r, lo_r} <= prod_fix;
            end
`else
            {hi_r, lo_r} <= prod_fix;
`endif
         end
      end
   end

endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq -- directed self-checking bench for mdu_seq (WIDTH=32).
// Divide vectors run only when MDU_SEQ_DIV_EN is defined; otherwise the
// bench checks that divide requests are refused.
module tb_mdu_seq;

   logic clk = 1'b0;
   logic rst_n;
   int   n_chk  = 0;
   int   n_pass = 0;
   int   lat;
   int   ndone;
   int   nbusy;

   always #5 clk = ~clk;

   mdu_seq_if #(.WIDTH(32)) bus ();

   mdu_seq #(.WIDTH(32), .CNT_W(6)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called at posedge+1: start is sampled at the next edge (E0). Returns
   // with lat = cycles from E0 to done (100 on timeout).
   task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] aa,
                         input logic [31:0] bb, input int inj, input logic we, output int l);
      bus.start = 1'b1; bus.op = o; bus.a = aa; bus.b = bb;
      bus.hi_we = we; bus.wdata = 32'h0000ABCD;
      tick();
      bus.start = 1'b0; bus.hi_we = 1'b0;
      bus.a = $urandom; bus.b = $urandom;
      chk({tag, ".busy_e0"}, bus.busy, 1);
      if (we) chk({tag, ".mthi_e0"}, bus.hi, 64'h0000ABCD);
      l = 0;
      while (!bus.done && l < 100) begin
         if (l == inj) begin
            bus.start = 1'b1; bus.op = 2'b01; bus.a = 1; bus.b = 1;
            bus.hi_we = 1'b1; bus.wdata = 32'h55;
         end else begin
            bus.start = 1'b0; bus.hi_we = 1'b0;
         end
         tick();
         l++;
      end
      bus.start = 1'b0; bus.hi_we = 1'b0;
      chk({tag, ".lat"}, l, 33);
   endtask

   initial begin
      rst_n = 1'b0;
      bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
      bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
      #2;
      chk("rst.busy", bus.busy, 0);
      chk("rst.done", bus.done, 0);
      chk("rst.hi", bus.hi, 0);
      chk("rst.lo", bus.lo, 0);
      chk("rst.dz", bus.div_zero, 0);
      #10 rst_n = 1'b1;
      tick();

      // MULTU max*max, then done must be a single-cycle pulse
      run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, 1'b0, lat);
      chk("multu_max.hi", bus.hi, 64'hFFFFFFFE);
      chk("multu_max.lo", bus.lo, 64'h00000001);
      tick();
      chk("multu_max.done_pulse", bus.done, 0);
      chk("multu_max.busy_after", bus.busy, 0);

      // direct writes while idle
      bus.hi_we = 1'b1; bus.wdata = 32'h12345678;
      tick();
      bus.hi_we = 1'b0; bus.lo_we = 1'b1; bus.wdata = 32'h9ABCDEF0;
      tick();
      bus.lo_we = 1'b0;
      chk("mthi", bus.hi, 64'h12345678);
      chk("mtlo", bus.lo, 64'h9ABCDEF0);

      // MULT -3*5; next op issued back-to-back in the done cycle
      run_op("mult_neg", 2'b00, 32'hFFFFFFFD, 32'd5, -1, 1'b0, lat);
      chk("mult_neg.hi", bus.hi, 64'hFFFFFFFF);
      chk("mult_neg.lo", bus.lo, 64'hFFFFFFF1);

`ifdef MDU_SEQ_DIV_EN
      run_op("div_neg", 2'b10, 32'hFFFFFFF9, 32'd2, -1, 1'b0, lat);
      chk("div_neg.lo", bus.lo, 64'hFFFFFFFD);
      chk("div_neg.hi", bus.hi, 64'hFFFFFFFF);

      run_op("divu_zero", 2'b11, 32'd10, 32'd0, -1, 1'b0, lat);
      chk("divu_zero.lo", bus.lo, 64'hFFFFFFFF);
      chk("divu_zero.hi", bus.hi, 64'h0000000A);
      chk("divu_zero.dz", bus.div_zero, 1);

      // accept must clear div_zero at E0; hi_we with start lands at E0
      bus.start = 1'b1; bus.op = 2'b01; bus.a = 2; bus.b = 3;
      bus.hi_we = 1'b1; bus.wdata = 32'h0000ABCD;
      tick();
      bus.start = 1'b0; bus.hi_we = 1'b0;
      chk("multu_23.dz_e0", bus.div_zero, 0);
      chk("multu_23.mthi_e0", bus.hi, 64'h0000ABCD);
      lat = 0;
      while (!bus.done && lat < 100) begin tick(); lat++; end
      chk("multu_23.lat", lat, 33);
      chk("multu_23.hi", bus.hi, 0);
      chk("multu_23.lo", bus.lo, 6);

      run_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, -1, 1'b0, lat);
      chk("div_ovf.lo", bus.lo, 64'h80000000);
      chk("div_ovf.hi", bus.hi, 0);
      chk("div_ovf.dz", bus.div_zero, 0);
`else
      // divide request refused: no busy, no done, hi/lo untouched
      bus.start = 1'b1; bus.op = 2'b10; bus.a = 32'd20; bus.b = 32'd3;
      nbusy = 0; ndone = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         bus.start = (i < 3);
         if (bus.busy) nbusy++;
         if (bus.done) ndone++;
      end
      bus.start = 1'b0;
      chk("nodiv.busy", nbusy, 0);
      chk("nodiv.done", ndone, 0);
      chk("nodiv.hi", bus.hi, 64'hFFFFFFFF);
      chk("nodiv.lo", bus.lo, 64'hFFFFFFF1);
      chk("nodiv.dz", bus.div_zero, 0);
`endif

      // start and hi_we during RUN are ignored
      run_op("multu_79", 2'b01, 32'd7, 32'd9, 10, 1'b0, lat);
      chk("multu_79.hi", bus.hi, 0);
      chk("multu_79.lo", bus.lo, 63);
      tick();
      chk("multu_79.done_pulse", bus.done, 0);
      chk("multu_79.busy_after", bus.busy, 0);

      // reset in the middle of an operation
      run_op("mult_seed", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, 1'b0, lat);
      chk("mult_seed.lo", bus.lo, 1);
`ifdef MDU_SEQ_DIV_EN
      bus.start = 1'b1; bus.op = 2'b11; bus.a = 32'd100; bus.b = 32'd7;
`else
      bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'd100; bus.b = 32'd7;
`endif
      tick();
      bus.start = 1'b0;
      repeat (11) tick();
      rst_n = 1'b0;
      #1;
      chk("abort.hi", bus.hi, 0);
      chk("abort.lo", bus.lo, 0);
      chk("abort.busy", bus.busy, 0);
      chk("abort.done", bus.done, 0);
      #2 rst_n = 1'b1;
      ndone = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (bus.done) ndone++;
      end
      chk("abort.no_done", ndone, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/mdu_seq.md
MDU_SEQ -- requirements
Module: mdu_seq

Interface
REQ-001 The block SHALL take parameter WIDTH, default 32, which sets the operand and result width; legal values are 8 to 64, even.
REQ-002 The block SHALL take parameter CNT_W, default 6, which sets the iteration counter width; it SHALL satisfy 2**CNT_W > WIDTH.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  request a new operation; sampled only in IDLE.
REQ-006 op  in  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
REQ-007 a  in  WIDTH  multiplicand or dividend.
REQ-008 b  in  WIDTH  multiplier or divisor.
REQ-009 hi_we  in  1  load hi from wdata (MTHI).
REQ-010 lo_we  in  1  load lo from wdata (MTLO).
REQ-011 wdata  in  WIDTH  direct-write data.
REQ-012 busy  out  1  operation in progress.
REQ-013 done  out  1  one-cycle pulse; hi and lo hold the new result.
REQ-014 hi  out  WIDTH  product upper half or remainder, registered.
REQ-015 lo  out  WIDTH  product lower half or quotient, registered.
REQ-016 div_zero  out  1  last completed divide had b == 0; sticky until the next accepted start.

Function
REQ-017 FSM states SHALL be IDLE, RUN and FIX; reset state is IDLE.
REQ-018 Accept: start=1 in IDLE at edge E0 latches op, |a|, |b| and the result signs, loads the counter with WIDTH, and enters RUN; busy=1 from E0.
REQ-019 RUN SHALL perform exactly one radix-2 step per cycle: shift-add for multiply, restoring subtract for divide; the counter decrements each edge; RUN exits to FIX on the WIDTH-th RUN edge.
REQ-020 FIX (edge E0+WIDTH+1) SHALL apply the sign correction, write hi and lo, pulse done=1 for exactly one cycle, clear busy, and return to IDLE.
REQ-021 Latency SHALL be exactly WIDTH+1 cycles from the accept edge to done; back-to-back start is accepted in the cycle done is high.
REQ-022 Multiply SHALL produce the exact 2*WIDTH-bit product in two's complement (MULT) or unsigned (MULTU): hi = upper half, lo = lower half.
REQ-023 Divide SHALL set lo = quotient truncated toward zero and hi = remainder carrying the sign of the dividend.
REQ-024 Divide by zero SHALL set lo = all ones, hi = a unmodified, div_zero=1, with no sign correction and the same latency.
REQ-025 Signed overflow (a = most-negative value, b = -1) SHALL set lo = most-negative value, hi = 0, div_zero=0.
REQ-026 start while busy SHALL be ignored with no side effects.
REQ-027 hi_we and lo_we SHALL update their register at the edge only while busy=0; they are ignored while busy=1.
REQ-028 hi_we/lo_we asserted together with an accepted start SHALL take effect at E0; the FIX write then overwrites them.
REQ-029 An accepted start SHALL clear div_zero at E0.
REQ-030 Operand inputs SHALL be don't-care after E0.

Reset
REQ-031 rst_n=0 SHALL immediately force IDLE with busy=0, done=0, hi=0, lo=0, div_zero=0 and the counter at 0.
REQ-032 Reset asserted mid-operation SHALL abort the operation with no done pulse; the first edge after release is a normal IDLE cycle.

Configuration
REQ-033 With macro MDU_SEQ_DIV_EN defined, the divide datapath, DIV/DIVU and div_zero SHALL operate as specified above.
REQ-034 With MDU_SEQ_DIV_EN undefined, the divide datapath SHALL be removed: start with op[1]=1 is not accepted (busy stays 0, no done, hi/lo unchanged), div_zero is tied 0, and multiply is unchanged.

Verification (WIDTH=32, MDU_SEQ_DIV_EN defined unless noted)
REQ-035 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> done exactly 33 cycles after accept; hi=0xFFFFFFFE, lo=0x00000001.
REQ-036 MULT a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; then DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-037 DIVU a=10, b=0 -> lo=0xFFFFFFFF, hi=0x0000000A, div_zero=1; a following MULTU 2*3 clears div_zero at accept, then hi=0, lo=6.
REQ-038 DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0.
REQ-039 MULTU 7*9 with start re-pulsed and hi_we=1, wdata=0x55 on cycle 10 -> both ignored; single done with hi=0, lo=63.
REQ-040 rst_n low on cycle 12 of a DIVU -> hi=lo=0 and busy=0 immediately, no done; with MDU_SEQ_DIV_EN undefined, start op=10 -> busy stays 0 and no done within 40 cycles.
